// File: rtl/clock_time_counter.sv
// hh:mm:ss BCD time-of-day counter with tick prescaler, 24h/12h modes and
// a validated parallel time-set load. All outputs registered.
module clock_time_counter #(
  parameter int MODE_24  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [23:0] i_load_time,
  input  logic        i_load_pm,
  output logic [23:0] o_time_bcd,
  output logic        o_pm,
  output logic        o_sec_tick,
  output logic        o_min_tick,
  output logic        o_hr_tick,
  output logic        o_day_wrap,
  output logic        o_load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] RST_HR_T = (MODE_24 != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0] RST_HR_O = (MODE_24 != 0) ? 4'd0 : 4'd2;

  logic [PW-1:0] r_presc;
  logic [3:0]    r_hr_t, r_hr_o, r_min_t, r_min_o, r_sec_t, r_sec_o;
  logic          r_pm;
  logic          r_sec_tick, r_min_tick, r_hr_tick, r_day_wrap, r_load_err;

  logic       w_step, w_sec_o_wrap, w_sec_wrap, w_min_o_wrap, w_min_wrap;
  logic       w_c_sec_t, w_c_min_o, w_c_min_t, w_c_hr;
  logic [3:0] w_hr_t_nxt, w_hr_o_nxt;
  logic       w_pm_nxt, w_day;
  logic [3:0] w_ld_hr_t, w_ld_hr_o, w_ld_min_t, w_ld_min_o, w_ld_sec_t, w_ld_sec_o;
  logic       w_dig_ok, w_ms_ok, w_hr_ok, w_load_ok;

  // Ripple carry chain: each digit advances on the same edge as the step.
  assign w_step       = i_en && (r_presc == PRE_MAX);
  assign w_sec_o_wrap = (r_sec_o == 4'd9);
  assign w_sec_wrap   = w_sec_o_wrap && (r_sec_t == 4'd5);
  assign w_min_o_wrap = (r_min_o == 4'd9);
  assign w_min_wrap   = w_min_o_wrap && (r_min_t == 4'd5);
  assign w_c_sec_t    = w_step && w_sec_o_wrap;
  assign w_c_min_o    = w_step && w_sec_wrap;
  assign w_c_min_t    = w_c_min_o && w_min_o_wrap;
  assign w_c_hr       = w_c_min_o && w_min_wrap;

  always_comb begin
    w_hr_t_nxt = r_hr_t;
    w_hr_o_nxt = r_hr_o + 4'd1;
    w_pm_nxt   = r_pm;
    w_day      = 1'b0;
    if (MODE_24 != 0) begin
      if (r_hr_t == 4'd2 && r_hr_o == 4'd3) begin
        w_hr_t_nxt = 4'd0;
        w_hr_o_nxt = 4'd0;
        w_day      = 1'b1;
      end else if (r_hr_o == 4'd9) begin
        w_hr_t_nxt = r_hr_t + 4'd1;
        w_hr_o_nxt = 4'd0;
      end
    end else begin
      // 11 -> 12 flips the meridiem; only 11 PM -> 12 AM is a new day
      if (r_hr_t == 4'd1 && r_hr_o == 4'd1) begin
        w_hr_o_nxt = 4'd2;
        w_pm_nxt   = ~r_pm;
        w_day      = r_pm;
      end else if (r_hr_t == 4'd1 && r_hr_o == 4'd2) begin
        w_hr_t_nxt = 4'd0;
        w_hr_o_nxt = 4'd1;
      end else if (r_hr_o == 4'd9) begin
        w_hr_t_nxt = 4'd1;
        w_hr_o_nxt = 4'd0;
      end
    end
  end

  assign {w_ld_hr_t, w_ld_hr_o, w_ld_min_t, w_ld_min_o, w_ld_sec_t, w_ld_sec_o} = i_load_time;
  assign w_dig_ok = (w_ld_hr_t <= 4'd9) && (w_ld_hr_o <= 4'd9) && (w_ld_min_t <= 4'd9) &&
                    (w_ld_min_o <= 4'd9) && (w_ld_sec_t <= 4'd9) && (w_ld_sec_o <= 4'd9);
  assign w_ms_ok  = (w_ld_min_t <= 4'd5) && (w_ld_sec_t <= 4'd5);
  assign w_hr_ok  = (MODE_24 != 0) ?
                    ((w_ld_hr_t <= 4'd1) || (w_ld_hr_t == 4'd2 && w_ld_hr_o <= 4'd3)) :
                    ((w_ld_hr_t == 4'd0 && w_ld_hr_o != 4'd0) ||
                     (w_ld_hr_t == 4'd1 && w_ld_hr_o <= 4'd2));
  assign w_load_ok = i_load && w_dig_ok && w_ms_ok && w_hr_ok;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc    <= '0;
      r_hr_t     <= RST_HR_T;
      r_hr_o     <= RST_HR_O;
      r_min_t    <= 4'd0;
      r_min_o    <= 4'd0;
      r_sec_t    <= 4'd0;
      r_sec_o    <= 4'd0;
      r_pm       <= 1'b0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
      r_hr_tick  <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else if (w_load_ok) begin
      r_presc    <= '0;
      {r_hr_t, r_hr_o, r_min_t, r_min_o, r_sec_t, r_sec_o} <= i_load_time;
      r_pm       <= (MODE_24 != 0) ? 1'b0 : i_load_pm;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
      r_hr_tick  <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_step;
      r_min_tick <= w_c_min_o;
      r_hr_tick  <= w_c_hr;
      r_day_wrap <= w_c_hr && w_day;
      r_load_err <= i_load;
      if (i_en) r_presc <= w_step ? '0 : r_presc + PW'(1);
      if (w_step)    r_sec_o <= w_sec_o_wrap ? 4'd0 : r_sec_o + 4'd1;
      if (w_c_sec_t) r_sec_t <= (r_sec_t == 4'd5) ? 4'd0 : r_sec_t + 4'd1;
      if (w_c_min_o) r_min_o <= w_min_o_wrap ? 4'd0 : r_min_o + 4'd1;
      if (w_c_min_t) r_min_t <= (r_min_t == 4'd5) ? 4'd0 : r_min_t + 4'd1;
      if (w_c_hr) begin
        r_hr_t <= w_hr_t_nxt;
        r_hr_o <= w_hr_o_nxt;
        r_pm   <= w_pm_nxt;
      end
    end
  end

  assign o_time_bcd = {r_hr_t, r_hr_o, r_min_t, r_min_o, r_sec_t, r_sec_o};
  assign o_pm       = r_pm;
  assign o_sec_tick = r_sec_tick;
  assign o_min_tick = r_min_tick;
  assign o_hr_tick  = r_hr_tick;
  assign o_day_wrap = r_day_wrap;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench: three counters (24h/div1, 24h/div4, 12h/div1) share stimulus;
// a seconds-of-day model predicts each one, a monitor pops and compares every cycle.
module tb_clock_time_counter;

  typedef struct packed {
    logic [23:0] t;
    logic        pm;
    logic [4:0]  p;   // {sec, min, hr, day, err}
  } rec_t;
  typedef rec_t [2:0] trio_t;

  logic        clk = 1'b0;
  logic        reset, en, load, load_pm;
  logic [23:0] load_time;

  logic [23:0] t0, t1, t2;
  logic        pm0, pm1, pm2;
  logic        st0, st1, st2, mt0, mt1, mt2, ht0, ht1, ht2, dw0, dw1, dw2, le0, le1, le2;

  trio_t q[$];
  int    m_s[3];
  int    m_pre[3];
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  clock_time_counter #(.MODE_24(1), .TICK_DIV(1)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_load(load), .i_load_time(load_time),
    .i_load_pm(load_pm), .o_time_bcd(t0), .o_pm(pm0), .o_sec_tick(st0), .o_min_tick(mt0),
    .o_hr_tick(ht0), .o_day_wrap(dw0), .o_load_err(le0));
  clock_time_counter #(.MODE_24(1), .TICK_DIV(4)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_load(load), .i_load_time(load_time),
    .i_load_pm(load_pm), .o_time_bcd(t1), .o_pm(pm1), .o_sec_tick(st1), .o_min_tick(mt1),
    .o_hr_tick(ht1), .o_day_wrap(dw1), .o_load_err(le1));
  clock_time_counter #(.MODE_24(0), .TICK_DIV(1)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_load(load), .i_load_time(load_time),
    .i_load_pm(load_pm), .o_time_bcd(t2), .o_pm(pm2), .o_sec_tick(st2), .o_min_tick(mt2),
    .o_hr_tick(ht2), .o_day_wrap(dw2), .o_load_err(le2));

  function automatic bit m24_of(int k);
    return k != 2;
  endfunction

  function automatic int div_of(int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic rec_t disp(int s, bit m24);
    rec_t r;
    int h, mi, se, hd;
    h  = s / 3600;
    mi = (s / 60) % 60;
    se = s % 60;
    r.pm = 1'b0;
    hd = h;
    if (!m24) begin
      r.pm = (h >= 12);
      hd = (h % 12 == 0) ? 12 : h % 12;
    end
    r.t = {4'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    r.p = 5'b0;
    return r;
  endfunction

  function automatic bit load_ok(logic [23:0] lt, bit m24);
    int h;
    for (int i = 0; i < 6; i++) if (int'(lt[i*4 +: 4]) > 9) return 1'b0;
    if (int'(lt[15:12]) > 5 || int'(lt[7:4]) > 5) return 1'b0;
    h = int'(lt[23:20]) * 10 + int'(lt[19:16]);
    if (m24) return h <= 23;
    return (h >= 1) && (h <= 12);
  endfunction

  function automatic int decode(logic [23:0] lt, bit lpm, bit m24);
    int h;
    h = int'(lt[23:20]) * 10 + int'(lt[19:16]);
    if (!m24) h = (h % 12) + (lpm ? 12 : 0);
    return h * 3600 + (int'(lt[15:12]) * 10 + int'(lt[11:8])) * 60 +
           int'(lt[7:4]) * 10 + int'(lt[3:0]);
  endfunction

  // Effect of one clock edge on instance k, returns the expected post-edge outputs.
  function automatic rec_t model_step(int k, bit e, bit ld, logic [23:0] lt, bit lpm, bit rst);
    rec_t r;
    bit sec, mn, hr, day, err;
    {sec, mn, hr, day, err} = 5'b0;
    if (rst) begin
      m_s[k] = 0;
      m_pre[k] = 0;
    end else if (ld && load_ok(lt, m24_of(k))) begin
      m_s[k] = decode(lt, lpm, m24_of(k));
      m_pre[k] = 0;
    end else begin
      err = ld;
      if (e) begin
        m_pre[k]++;
        if (m_pre[k] == div_of(k)) begin
          m_pre[k] = 0;
          m_s[k] = (m_s[k] + 1) % 86400;
          sec = 1'b1;
          mn  = (m_s[k] % 60 == 0);
          hr  = (m_s[k] % 3600 == 0);
          day = (m_s[k] == 0);
        end
      end
    end
    r = disp(m_s[k], m24_of(k));
    r.p = {sec, mn, hr, day, err};
    return r;
  endfunction

  task automatic cyc(input bit e, input bit ld, input logic [23:0] lt, input bit lpm, input bit rst);
    trio_t x;
    @(negedge clk);
    en = e; load = ld; load_time = lt; load_pm = lpm; reset = rst;
    for (int k = 0; k < 3; k++) x[k] = model_step(k, e, ld, lt, lpm, rst);
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input int k, input logic [23:0] a, input logic [23:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, a, x);
    end
  endtask

  initial begin : monitor
    trio_t x, act;
    forever begin
      @(posedge clk);
      #1;
      act[0] = {t0, pm0, st0, mt0, ht0, dw0, le0};
      act[1] = {t1, pm1, st1, mt1, ht1, dw1, le1};
      act[2] = {t2, pm2, st2, mt2, ht2, dw2, le2};
      if (q.size() > 0) begin
        x = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("time_bcd", k, act[k].t, x[k].t);
          chk("pm", k, 24'(act[k].pm), 24'(x[k].pm));
          chk("pulses{sec,min,hr,day,err}", k, 24'(act[k].p), 24'(x[k].p));
        end
      end
    end
  end

  initial begin : driver
    logic [23:0] lt;
    reset = 1'b1; en = 1'b0; load = 1'b0; load_time = '0; load_pm = 1'b0;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 24'h235959, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 24'h115959, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 24'h125959, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 24'h115959, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 24'h240000, 0, 0);
    cyc(0, 1, 24'h006000, 0, 0);
    cyc(0, 1, 24'h000000, 0, 0);
    cyc(0, 1, 24'h000005, 0, 0);
    cyc(1, 1, 24'h240000, 0, 0);
    cyc(0, 1, 24'h005959, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 24'h010203, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      lt = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 6)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 1) == 1) lt[15:0] = 16'h5959;
      if ($urandom_range(0, 3) == 0) lt[7:0] = 8'h5A;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, lt, 1'($urandom_range(0, 1)),
          $urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 0, 24'(q.size()), 24'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

Parametrised hh:mm:ss time-of-day counter for the clock datapath, built as a chain of BCD digit counters with per-digit modulo limits and ripple carries. It divides a qualified tick enable down to one-second steps, and supports 24-hour or 12-hour (AM/PM) mode. It also provides a validated parallel time-set load. Outputs feed the display mux and alarm compare directly.

## Interface
- MODE_24, default 1: 1 = 24-hour mode (00:00:00–23:59:59); 0 = 12-hour mode (12:00:00–11:59:59 with pm flag).
- TICK_DIV, default 1: number of `en` pulses per one-second step. Legal range 1..2^16. PW = max(1, $clog2(TICK_DIV)).
- clk, input, 1: single clock. All state changes on the rising edge only.
- reset, input, 1: synchronous, active-high.
- en, input, 1: tick qualifier. Each high-sampled cycle counts one prescaler tick.
- load, input, 1: time-set request, single-cycle strobe.
- load_time, input, 24: packed BCD {hr_t, hr_o, min_t, min_o, sec_t, sec_o}, 4 bits each.
- load_pm, input, 1: pm value applied on load. Ignored when MODE_24=1.
- time_bcd, output, 24: current time, same packing as load_time.
- pm, output, 1: 12-hour PM flag. Constant 0 when MODE_24=1.
- sec_tick, output, 1: one-cycle pulse on each second step.
- min_tick, output, 1: one-cycle pulse when seconds wrap 59→00.
- hr_tick, output, 1: one-cycle pulse when minutes wrap 59→00.
- day_wrap, output, 1: one-cycle pulse when the day rolls over.
- load_err, output, 1: one-cycle pulse when a load is rejected.

## Operation
- Reset values:
  - time_bcd = 00:00:00 (MODE_24=1) or 12:00:00 (MODE_24=0).
  - pm = 0.
  - Prescaler = 0.
  - All pulse outputs = 0.
- Priority per edge: reset > valid load > count.
- Prescaler, PW bits:
  - On en=1 with prescaler < TICK_DIV-1: increment.
  - On en=1 with prescaler == TICK_DIV-1: clear to 0 and perform a second step.
  - en=0: hold.
  - TICK_DIV=1: every en cycle is a second step.
- Second step (digits advance together on the same edge, ripple carry is combinational):
  - sec_o: 0..9. Carry on 9.
  - sec_t: 0..5. Carry on 5 when sec_o=9.
  - min_o and min_t: same limits, enabled by the seconds carry.
- Hours, 24-hour mode: 23:59:59 → 00:00:00, with day_wrap.
- Hours, 12-hour mode:
  - 11:59:59 → 12:00:00 with pm toggled.
  - 12:59:59 → 01:00:00 with pm unchanged.
  - day_wrap fires only on 11:59:59 PM → 12:00:00 AM.
- Load validity:
  - Every digit ≤ 9.
  - sec_t ≤ 5 and min_t ≤ 5.
  - Hours in 0..23 (24-hour mode) or 1..12 (12-hour mode).
- Valid load:
  - time_bcd ← load_time; pm ← load_pm (12-hour mode).
  - Prescaler ← 0.
  - No tick pulses are generated that cycle, and any coincident en is discarded.
- Invalid load:
  - load_err = 1 for one cycle.
  - State advances exactly as if load = 0, including any coincident en tick.

## Timing
- All outputs are registered. time_bcd and pm update on the edge where the step is taken.
- Each pulse is asserted for the cycle immediately after that edge, aligned with the new time_bcd value.
- Latencies from the sampling edge:
  - en → time_bcd change: 1 cycle when the prescaler is at TICK_DIV-1.
  - load → time_bcd: 1 cycle.
  - load → load_err: 1 cycle.
- Nested rollovers share one cycle. At 23:59:59, sec_tick, min_tick, hr_tick and day_wrap all pulse together.
- Reset asserted mid-count clears everything on that edge. Pulses due on that edge are suppressed.
- Back-to-back en at TICK_DIV=1 yields one step per cycle, with no lost carries.

## Test plan
- Reset, then 60 en pulses, TICK_DIV=1, MODE_24=1 → time_bcd 00:01:00. sec_tick seen 60 times; min_tick once, on the last step.
- TICK_DIV=4, 7 en pulses with gaps → time_bcd 00:00:01. Prescaler = 3; the next en gives 00:00:02.
- MODE_24=1: load 23:59:59, then 1 en → 00:00:00. sec_tick, min_tick, hr_tick and day_wrap all pulse in the same cycle.
- MODE_24=0:
  - Load 11:59:59 AM + en → 12:00:00 with pm=1 and no day_wrap.
  - Load 12:59:59 PM + en → 01:00:00 with pm=1.
  - Load 11:59:59 PM + en → 12:00:00 with pm=0 and day_wrap.
- Load 24:00:00 (MODE_24=1), load 00:60:00, and load 00:00:00 (MODE_24=0) → load_err pulses each time and time_bcd is unchanged. An invalid load plus en at 00:00:05 → 00:00:06 with load_err.
- Reset asserted on the edge of an expected rollover at 00:59:59 → 00:00:00 and no pulses. A valid load coinciding with en → loaded value with no step taken.
